// File: rtl/fifo_row_packer_pkg.sv
// Shared defaults for the EKF element-to-row packer: element width, covariance
// row/matrix dimensions and the valid/ready handshake helper.
package fifo_row_packer_pkg;

  localparam int DATA_LEN_DEF = 8;
  localparam int ROW_LEN_DEF  = 4;
  localparam int ROWS_DEF     = 4;
  localparam int CNT_W_DEF    = 3;
  localparam int ROW_W_DEF    = 2;

  function automatic logic hsFire(input logic valid, input logic ready);
    return valid && ready;
  endfunction

endpackage

// File: rtl/fifo_row_packer.sv
// Drains scalar elements from the datapath sync_fifo (1-cycle read latency),
// packs ROW_LEN of them per row word and hands rows downstream on valid/ready.
module fifo_row_packer
  import fifo_row_packer_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int ROW_LEN  = ROW_LEN_DEF,
  parameter int ROWS     = ROWS_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int ROW_W    = ROW_W_DEF
) (
  input  logic                         clk,
  input  logic                         sys_rst_n,
  input  logic                         clr,
  input  logic                         en,
  input  logic                         fifo_empty,
  input  logic [DATA_LEN-1:0]          fifo_data,
  output logic                         fifo_rd_en,
  output logic [DATA_LEN*ROW_LEN-1:0]  out_data,
  output logic                         out_valid,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic [ROW_W-1:0]             row_idx,
  output logic                         busy
);

  localparam logic [CNT_W:0]   ROW_LEN_EXT = (CNT_W+1)'(ROW_LEN);
  localparam logic [CNT_W-1:0] ROW_FULL    = CNT_W'(ROW_LEN);
  localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(ROWS - 1);

  logic [CNT_W-1:0]            r_elemCnt;
  logic                        r_pending;
  logic [DATA_LEN*ROW_LEN-1:0] r_pack;
  logic [ROW_W-1:0]            r_frameRow;
  logic [DATA_LEN*ROW_LEN-1:0] r_outData;
  logic                        r_outValid;
  logic                        r_outLast;
  logic [ROW_W-1:0]            r_rowIdx;

  logic [CNT_W:0] w_fill;
  logic           w_room;
  logic           w_rowFull;
  logic           w_xfer;
  logic           w_outFire;

  // Counting the in-flight read against the row keeps at most ROW_LEN
  // elements committed to the pack register at any time.
  assign w_fill    = {1'b0, r_elemCnt} + (CNT_W+1)'(r_pending);
  assign w_room    = (w_fill < ROW_LEN_EXT);
  assign w_rowFull = (r_elemCnt == ROW_FULL);
  assign w_xfer    = w_rowFull && (!r_outValid || out_ready);
  assign w_outFire = hsFire(r_outValid, out_ready);

  assign fifo_rd_en = en && !clr && !fifo_empty && (w_room || w_xfer);

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_elemCnt <= '0;
      r_pending <= 1'b0;
    end else if (clr) begin
      r_elemCnt <= '0;
      r_pending <= 1'b0;
    end else begin
      r_pending <= fifo_rd_en;
      if (w_xfer)
        r_elemCnt <= '0;
      else if (r_pending)
        r_elemCnt <= r_elemCnt + CNT_W'(1);
    end
  end

  // A capture never coincides with a transfer: a full row implies no read in flight.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pack <= '0;
    end else if (!clr && r_pending) begin
      for (int s = 0; s < ROW_LEN; s++) begin
        if (r_elemCnt == CNT_W'(s))
          r_pack[s*DATA_LEN +: DATA_LEN] <= fifo_data;
      end
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_outData  <= '0;
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
      r_rowIdx   <= '0;
      r_frameRow <= '0;
    end else if (clr) begin
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
      r_rowIdx   <= '0;
      r_frameRow <= '0;
    end else if (w_xfer) begin
      r_outData  <= r_pack;
      r_outValid <= 1'b1;
      r_rowIdx   <= r_frameRow;
      r_outLast  <= (r_frameRow == LAST_ROW);
      r_frameRow <= (r_frameRow == LAST_ROW) ? '0 : r_frameRow + ROW_W'(1);
    end else if (w_outFire) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_data  = r_outData;
  assign out_valid = r_outValid;
  assign out_last  = r_outLast;
  assign row_idx   = r_rowIdx;
  assign busy      = (r_elemCnt != '0) || r_pending || r_outValid;

endmodule

// File: tb/tb_fifo_row_packer.sv
// Directed and randomized bench for fifo_row_packer; a queue-based FIFO model
// feeds the block and a scoreboard of consumed elements predicts each row.
module tb_fifo_row_packer;
  import fifo_row_packer_pkg::*;

  localparam int DL = DATA_LEN_DEF;
  localparam int RL = ROW_LEN_DEF;
  localparam int NR = ROWS_DEF;
  localparam int CW = CNT_W_DEF;
  localparam int RW = ROW_W_DEF;

  logic            clk = 1'b0;
  logic            sys_rst_n;
  logic            clr;
  logic            en;
  logic            fifo_empty;
  logic [DL-1:0]   fifo_data;
  logic            fifo_rd_en;
  logic [DL*RL-1:0] out_data;
  logic            out_valid;
  logic            out_last;
  logic            out_ready;
  logic [RW-1:0]   row_idx;
  logic            busy;

  fifo_row_packer #(
    .DATA_LEN(DL), .ROW_LEN(RL), .ROWS(NR), .CNT_W(CW), .ROW_W(RW)
  ) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .clr(clr), .en(en),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .row_idx(row_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [DL-1:0]    fifoQ[$];
  logic [DL-1:0]    modelBuf[$];
  int               modelFrame = 0;
  logic [DL*RL-1:0] gotData[$];
  logic             gotLast[$];
  int               gotIdx[$];
  int               readCount = 0;
  int               tickNum = 0;
  bit               rdSeen = 0;
  bit               measure = 0;
  int               firstRd = -1;
  int               firstVal = -1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DL*RL-1:0] headRow();
    logic [DL*RL-1:0] r;
    r = '0;
    for (int i = 0; i < RL; i++) r[i*DL +: DL] = modelBuf[i];
    return r;
  endfunction

  task automatic applyStimulus(input logic enV, input logic readyV, input logic clrV);
    en        = enV;
    out_ready = readyV;
    clr       = clrV;
  endtask

  task automatic pushElem(input logic [DL-1:0] v);
    fifoQ.push_back(v);
    fifo_empty = 1'b0;
  endtask

  // Scoreboard step at the negedge, FIFO read data delivered just after the posedge.
  task automatic tick();
    @(negedge clk);
    tickNum++;
    rdSeen = 0;
    if (!sys_rst_n) begin
      modelBuf.delete();
      modelFrame = 0;
    end else if (clr) begin
      checkOutput("rd_en_during_clr", 64'(fifo_rd_en), 64'd0);
      modelBuf.delete();
      modelFrame = 0;
    end else begin
      if (fifo_empty) checkOutput("rd_en_while_empty", 64'(fifo_rd_en), 64'd0);
      if (!en)        checkOutput("rd_en_while_en_low", 64'(fifo_rd_en), 64'd0);
      if (measure && firstRd < 0 && fifo_rd_en) firstRd = tickNum;
      if (measure && firstVal < 0 && out_valid) firstVal = tickNum;
      if (out_valid) begin
        if (modelBuf.size() < RL) begin
          checkOutput("valid_without_elements", 64'(modelBuf.size()), 64'(RL));
        end else begin
          checkOutput("row_data", 64'(out_data), 64'(headRow()));
          checkOutput("row_idx", 64'(row_idx), 64'(modelFrame));
          checkOutput("row_last", 64'(out_last), 64'(modelFrame == NR - 1));
          if (out_ready) begin
            gotData.push_back(out_data);
            gotLast.push_back(out_last);
            gotIdx.push_back(int'(row_idx));
            for (int i = 0; i < RL; i++) void'(modelBuf.pop_front());
            modelFrame = (modelFrame + 1) % NR;
          end
        end
      end
      if (fifo_rd_en) begin
        if (fifoQ.size() == 0) begin
          checkOutput("read_from_empty", 64'd1, 64'd0);
        end else begin
          modelBuf.push_back(fifoQ[0]);
          readCount++;
          rdSeen = 1;
        end
      end
      checkOutput("outstanding_bound", 64'(modelBuf.size() <= 2*RL), 64'd1);
    end
    @(posedge clk);
    #1;
    if (rdSeen) begin
      fifo_data  = fifoQ.pop_front();
      fifo_empty = (fifoQ.size() == 0);
    end
  endtask

  task automatic waitRows(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (gotData.size() >= target) break;
      tick();
    end
    checkOutput("rows_timeout", 64'(gotData.size() >= target), 64'd1);
  endtask

  initial begin
    int b;
    int r0;
    logic [DL*RL-1:0] expRow;
    logic [DL*RL-1:0] firstRows[4];
    firstRows[0] = 32'h04030201;
    firstRows[1] = 32'h08070605;
    firstRows[2] = 32'h0C0B0A09;
    firstRows[3] = 32'h100F0E0D;

    sys_rst_n  = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (2) tick();
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_data", 64'(out_data), 64'd0);
    checkOutput("reset_out_last", 64'(out_last), 64'd0);
    checkOutput("reset_row_idx", 64'(row_idx), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_rd_en", 64'(fifo_rd_en), 64'd0);
    sys_rst_n = 1'b1;
    tick();

    $display("[TB] continuous stream of 16 elements");
    b = gotData.size();
    measure = 1;
    for (int v = 1; v <= 16; v++) pushElem(DL'(v));
    waitRows(b + 4, 60);
    measure = 0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("stream_row", 64'(gotData[b+i]), 64'(firstRows[i]));
      checkOutput("stream_idx", 64'(gotIdx[b+i]), 64'(i));
      checkOutput("stream_last", 64'(gotLast[b+i]), 64'(i == 3));
    end
    // Ticks from rd_en sample to valid sample, less the accepting edge, gives edge latency.
    checkOutput("first_row_latency", 64'(firstVal - firstRd - 1), 64'(RL + 1));

    $display("[TB] backpressure for 20 cycles");
    b  = gotData.size();
    r0 = readCount;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int v = 1; v <= 16; v++) pushElem(DL'(v));
    repeat (20) tick();
    checkOutput("stall_reads", 64'(readCount - r0), 64'(2*RL));
    checkOutput("stall_valid", 64'(out_valid), 64'd1);
    checkOutput("stall_data", 64'(out_data), 64'(firstRows[0]));
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitRows(b + 4, 60);
    for (int i = 0; i < 4; i++) begin
      checkOutput("stall_row", 64'(gotData[b+i]), 64'(firstRows[i]));
      checkOutput("stall_row_idx", 64'(gotIdx[b+i]), 64'(i));
    end

    $display("[TB] FIFO runs dry mid-row");
    b = gotData.size();
    pushElem(8'h01);
    pushElem(8'h02);
    repeat (10) tick();
    checkOutput("dry_rd_en", 64'(fifo_rd_en), 64'd0);
    checkOutput("dry_valid", 64'(out_valid), 64'd0);
    checkOutput("dry_busy", 64'(busy), 64'd1);
    pushElem(8'h03);
    pushElem(8'h04);
    waitRows(b + 1, 30);
    checkOutput("dry_row", 64'(gotData[b]), 64'(firstRows[0]));
    checkOutput("dry_idx", 64'(gotIdx[b]), 64'd0);

    $display("[TB] clear with a read in flight");
    b  = gotData.size();
    r0 = readCount;
    for (int v = 0; v < 4; v++) pushElem(DL'(8'h11 + v));
    for (int i = 0; i < 30; i++) begin
      if (readCount - r0 >= 4) break;
      tick();
    end
    checkOutput("clr_reads_before", 64'(readCount - r0), 64'd4);
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("clr_valid", 64'(out_valid), 64'd0);
    checkOutput("clr_busy", 64'(busy), 64'd0);
    checkOutput("clr_row_idx", 64'(row_idx), 64'd0);
    for (int v = 0; v < 4; v++) pushElem(DL'(8'h21 + v));
    waitRows(b + 1, 30);
    checkOutput("clr_no_partial_row", 64'(gotData.size()), 64'(b + 1));
    checkOutput("clr_next_row", 64'(gotData[b]), 64'h24232221);
    checkOutput("clr_next_idx", 64'(gotIdx[b]), 64'd0);
    checkOutput("clr_next_last", 64'(gotLast[b]), 64'd0);

    $display("[TB] en toggling every other cycle");
    b  = gotData.size();
    r0 = readCount;
    for (int v = 0; v < 8; v++) pushElem(DL'(8'h31 + v));
    for (int i = 0; i < 80; i++) begin
      if (gotData.size() >= b + 2) break;
      applyStimulus(logic'(i % 2 == 0), 1'b1, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("en_rows", 64'(gotData.size()), 64'(b + 2));
    checkOutput("en_row0", 64'(gotData[b]), 64'h34333231);
    checkOutput("en_row1", 64'(gotData[b+1]), 64'h38373635);
    checkOutput("en_reads", 64'(readCount - r0), 64'd8);

    $display("[TB] asynchronous reset mid-row");
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int v = 0; v < 6; v++) pushElem(DL'($urandom));
    repeat (12) tick();
    checkOutput("pre_reset_valid", 64'(out_valid), 64'd1);
    checkOutput("pre_reset_idx", 64'(row_idx), 64'd3);
    checkOutput("pre_reset_last", 64'(out_last), 64'd1);
    #2;
    sys_rst_n = 1'b0;
    fifoQ.delete();
    fifo_empty = 1'b1;
    #1;
    checkOutput("arst_valid", 64'(out_valid), 64'd0);
    checkOutput("arst_data", 64'(out_data), 64'd0);
    checkOutput("arst_last", 64'(out_last), 64'd0);
    checkOutput("arst_idx", 64'(row_idx), 64'd0);
    checkOutput("arst_busy", 64'(busy), 64'd0);
    checkOutput("arst_rd_en", 64'(fifo_rd_en), 64'd0);
    repeat (2) tick();
    sys_rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    b = gotData.size();
    expRow = '0;
    for (int v = 0; v < 4; v++) begin
      logic [DL-1:0] d;
      d = DL'($urandom);
      expRow[v*DL +: DL] = d;
      pushElem(d);
    end
    waitRows(b + 1, 30);
    checkOutput("post_reset_row", 64'(gotData[b]), 64'(expRow));
    checkOutput("post_reset_idx", 64'(gotIdx[b]), 64'd0);
    checkOutput("post_reset_last", 64'(gotLast[b]), 64'd0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(logic'($urandom % 4 != 0), logic'($urandom % 3 != 0), logic'($urandom % 50 == 0));
      if (($urandom % 2 == 1) && fifoQ.size() < 10) pushElem(DL'($urandom));
      tick();
    end
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      if (fifoQ.size() == 0 && modelBuf.size() == 0 && !busy) break;
      if (fifoQ.size() == 0 && (modelBuf.size() % RL) != 0) begin
        int pad;
        pad = RL - (modelBuf.size() % RL);
        for (int p = 0; p < pad; p++) pushElem(DL'($urandom));
      end
      tick();
    end
    checkOutput("drain_model_empty", 64'(modelBuf.size()), 64'd0);
    checkOutput("drain_fifo_empty", 64'(fifoQ.size()), 64'd0);
    checkOutput("drain_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
